// File: rtl/dma_xfer_engine.sv
// Single-channel store-and-forward DMA engine: reads up to 16 words into a local
// buffer, then writes them out (or writes a constant pattern in fill mode).
module dma_xfer_engine #(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MEM_STRB_WIDTH = MEM_DATA_WIDTH / 8,
  parameter int MAX_TRANS_SIZE = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_start,
  input  logic [MEM_ADDR_WIDTH-1:0] cmd_src,
  input  logic [MEM_ADDR_WIDTH-1:0] cmd_dst,
  input  logic [MAX_TRANS_SIZE-1:0] cmd_len,
  input  logic                      cmd_mode,
  input  logic [MEM_DATA_WIDTH-1:0] cmd_fill,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata,
  output logic [MEM_STRB_WIDTH-1:0] mem_wstrb,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata
);
  localparam int AW        = MEM_ADDR_WIDTH;
  localparam int DW        = MEM_DATA_WIDTH;
  localparam int LW        = MAX_TRANS_SIZE;
  localparam int MAX_WORDS = 16;
  localparam int IDXW      = $clog2(MAX_WORDS);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_WORDS);
  localparam logic [LW-1:0] ONE     = LW'(1);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [LW-1:0] len_q, len_d, icnt_q, icnt_d, rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic          mode_q, mode_d, err_q, err_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [DW-1:0] buf_q [MAX_WORDS];
  logic          rd_cap;
  logic [AW-1:0] rd_addr, wr_addr;

  // Read beats may overlap the issue phase, so capture in every active state.
  assign rd_cap  = mem_rvalid && !mode_q && (rcnt_q < len_q) &&
                   (state_q == RD || state_q == RD_WAIT || state_q == WR);
  assign rd_addr = src_q + AW'({icnt_q, 2'b00});
  assign wr_addr = dst_q + AW'({wcnt_q, 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      err_q   <= 1'b0;
      icnt_q  <= '0;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      icnt_q  <= icnt_d;
      rcnt_q  <= rcnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_cap) buf_q[rcnt_q[IDXW-1:0]] <= mem_rdata;
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    mode_d    = mode_q;
    fill_d    = fill_q;
    err_d     = err_q;
    icnt_d    = icnt_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rd_cap ? rcnt_q + ONE : rcnt_q;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          src_d  = cmd_src;
          dst_d  = cmd_dst;
          len_d  = cmd_len;
          mode_d = cmd_mode;
          fill_d = cmd_fill;
          err_d  = (cmd_len > LEN_MAX);
          icnt_d = '0;
          rcnt_d = '0;
          wcnt_d = '0;
          if (cmd_len == '0 || cmd_len > LEN_MAX) state_d = DONE;
          else if (cmd_mode)                      state_d = WR;
          else                                    state_d = RD;
        end
      end
      RD: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = rd_addr;
        if (mem_gnt) begin
          icnt_d = icnt_q + ONE;
          if (icnt_q == len_q - ONE) state_d = (rcnt_d == len_q) ? WR : RD_WAIT;
        end
      end
      RD_WAIT: begin
        busy = 1'b1;
        if (rcnt_q == len_q) state_d = WR;
      end
      WR: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = mode_q ? fill_q : buf_q[wcnt_q[IDXW-1:0]];
        mem_wstrb = '1;
        if (mem_gnt) begin
          wcnt_d = wcnt_q + ONE;
          if (wcnt_q == len_q - ONE) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dma_xfer_engine.sv
// Directed bench for dma_xfer_engine with a simple memory model that supports
// grant back-pressure and in-order read returns with configurable delay.
module tb_dma_xfer_engine;
  localparam int AW = 16, DW = 32, SW = 4, LW = 5;

  logic          clk, rst_n, cmd_start, cmd_mode;
  logic [AW-1:0] cmd_src, cmd_dst;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_fill;
  logic          busy, done, err, mem_req, mem_we, mem_gnt;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata  = '0;

  int checks = 0, failures = 0;

  logic [DW-1:0] mem [0:16383];
  int gnt_wait = 0, rv_min = 1, rv_max = 1;
  int wait_cnt = 0, cyc = 0, last_due = 0;
  int            rq_due [$];
  logic [DW-1:0] rq_data[$];

  int n_req_cyc = 0, n_done = 0, n_err = 0, n_stab_bad = 0, n_hold = 0;
  int n_bad_strb = 0, n_rv_idle = 0;
  logic [AW-1:0] rd_log[$], wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  logic          hold_q = 1'b0, p_we = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic [SW-1:0] p_wstrb = '0;

  dma_xfer_engine dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_mode(cmd_mode), .cmd_fill(cmd_fill),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_gnt = mem_req && (wait_cnt >= gnt_wait);

  // Memory port model: reads return in order, at least one cycle after grant.
  always @(posedge clk) begin
    int due;
    cyc      <= cyc + 1;
    wait_cnt <= (mem_req && !mem_gnt) ? wait_cnt + 1 : 0;
    if (mem_req && mem_gnt && !mem_we) begin
      due = cyc + int'($urandom_range(rv_max, rv_min));
      if (due <= last_due) due = last_due + 1;
      rq_due.push_back(due);
      rq_data.push_back(mem[mem_addr[AW-1:2]]);
      last_due <= due;
    end
    mem_rvalid <= 1'b0;
    if (rq_due.size() > 0 && rq_due[0] <= cyc + 1) begin
      mem_rvalid <= 1'b1;
      mem_rdata  <= rq_data[0];
      void'(rq_due.pop_front());
      void'(rq_data.pop_front());
    end
  end

  always @(posedge clk) begin
    if (mem_req) n_req_cyc <= n_req_cyc + 1;
    if (done)    n_done    <= n_done + 1;
    if (err)     n_err     <= n_err + 1;
    if (mem_rvalid && !busy && rst_n) n_rv_idle <= n_rv_idle + 1;
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        wr_addr_log.push_back(mem_addr);
        wr_data_log.push_back(mem_wdata);
        if (mem_wstrb != 4'hF) n_bad_strb <= n_bad_strb + 1;
      end else begin
        rd_log.push_back(mem_addr);
        if (mem_wstrb != 4'h0) n_bad_strb <= n_bad_strb + 1;
      end
    end
    if (hold_q && rst_n && !(mem_req && mem_addr == p_addr && mem_we == p_we &&
                             mem_wdata == p_wdata && mem_wstrb == p_wstrb))
      n_stab_bad <= n_stab_bad + 1;
    if (mem_req && !mem_gnt) n_hold <= n_hold + 1;
    hold_q  <= rst_n && mem_req && !mem_gnt;
    p_addr  <= mem_addr;
    p_we    <= mem_we;
    p_wdata <= mem_wdata;
    p_wstrb <= mem_wstrb;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [LW-1:0] len, input logic mode, input logic [DW-1:0] fill,
                         input int sec_at, output int done_at, output int busy_n,
                         output logic err_at);
    int n;
    @(negedge clk);
    cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_mode = mode; cmd_fill = fill;
    cmd_start = 1'b1;
    n = 0; done_at = -1; busy_n = 0; err_at = 1'b0;
    while (done_at < 0 && n < 400) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (done) begin done_at = n; err_at = err; end
      cmd_start = (n == sec_at);
      if (n == sec_at) begin
        cmd_src = 16'h4000; cmd_dst = 16'h4100; cmd_len = 5'd3; cmd_mode = 1'b1;
        cmd_fill = 32'h0BAD0BAD;
      end
    end
    cmd_start = 1'b0;
    chk({tag, ".completed"}, done_at >= 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int rb, wb, nd, nr, ne, ns, nh, nb, nv, done_at, busy_n;
    logic err_at;
    logic [AW-1:0] wrap_a [4];
    for (int i = 0; i < 16384; i++) mem[i] = 32'hC0DE0000 | i;
    for (int k = 0; k < 4; k++) mem[14'h40 + k] = 32'h57 + k;
    wrap_a = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};

    rst_n = 1'b0; cmd_start = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    cmd_mode = 1'b0; cmd_fill = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.req", mem_req, 0);
    chk("rst.we", mem_we, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.wdata", mem_wdata, 0);
    chk("rst.wstrb", mem_wstrb, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait copy: exact cycle-level latency.
    rb = rd_log.size(); wb = wr_addr_log.size(); nd = n_done; nb = n_bad_strb;
    run_cmd("copy4", 16'h0100, 16'h0200, 5'd4, 1'b0, 32'h0, 0, done_at, busy_n, err_at);
    chk("copy4.done_at", done_at, 11);
    chk("copy4.busy_n", busy_n, 10);
    chk("copy4.err", err_at, 0);
    chk("copy4.ndone", n_done - nd, 1);
    chk("copy4.nrd", rd_log.size() - rb, 4);
    chk("copy4.nwr", wr_addr_log.size() - wb, 4);
    chk("copy4.strb", n_bad_strb - nb, 0);
    for (int k = 0; k < 4; k++) begin
      chk("copy4.raddr", rd_log[rb + k], 32'h0100 + 4 * k);
      chk("copy4.waddr", wr_addr_log[wb + k], 32'h0200 + 4 * k);
      chk("copy4.wdata", wr_data_log[wb + k], 32'h57 + k);
    end

    // Fill: no reads, 16 pattern writes.
    rb = rd_log.size(); wb = wr_addr_log.size(); nb = n_bad_strb;
    run_cmd("fill16", 16'h0000, 16'h0300, 5'd16, 1'b1, 32'hDEADBEEF, 0, done_at, busy_n, err_at);
    chk("fill16.done_at", done_at, 17);
    chk("fill16.err", err_at, 0);
    chk("fill16.nrd", rd_log.size() - rb, 0);
    chk("fill16.nwr", wr_addr_log.size() - wb, 16);
    chk("fill16.strb", n_bad_strb - nb, 0);
    for (int k = 0; k < 16; k++) begin
      chk("fill16.waddr", wr_addr_log[wb + k], 32'h0300 + 4 * k);
      chk("fill16.wdata", wr_data_log[wb + k], 32'hDEADBEEF);
    end

    // Illegal and empty lengths: no memory traffic.
    nr = n_req_cyc; ne = n_err;
    run_cmd("len17", 16'h0100, 16'h0200, 5'd17, 1'b0, 32'h0, 0, done_at, busy_n, err_at);
    chk("len17.done_at", done_at, 1);
    chk("len17.err", err_at, 1);
    chk("len17.nerr", n_err - ne, 1);
    chk("len17.nreq", n_req_cyc - nr, 0);
    nr = n_req_cyc; ne = n_err;
    run_cmd("len0", 16'h0100, 16'h0200, 5'd0, 1'b0, 32'h0, 0, done_at, busy_n, err_at);
    chk("len0.done_at", done_at, 1);
    chk("len0.err", err_at, 0);
    chk("len0.nerr", n_err - ne, 0);
    chk("len0.nreq", n_req_cyc - nr, 0);

    // Back-pressure: 3 stalled cycles per request, random read latency.
    gnt_wait = 3; rv_min = 1; rv_max = 4;
    rb = rd_log.size(); wb = wr_addr_log.size(); ns = n_stab_bad; nh = n_hold;
    run_cmd("bp3", 16'h0100, 16'h0600, 5'd3, 1'b0, 32'h0, 0, done_at, busy_n, err_at);
    chk("bp3.stalls_seen", n_hold - nh, 18);
    chk("bp3.stable", n_stab_bad - ns, 0);
    chk("bp3.nrd", rd_log.size() - rb, 3);
    chk("bp3.nwr", wr_addr_log.size() - wb, 3);
    for (int k = 0; k < 3; k++) begin
      chk("bp3.raddr", rd_log[rb + k], 32'h0100 + 4 * k);
      chk("bp3.waddr", wr_addr_log[wb + k], 32'h0600 + 4 * k);
      chk("bp3.wdata", wr_data_log[wb + k], 32'h57 + k);
    end
    gnt_wait = 0; rv_min = 1; rv_max = 1;

    // Address wrap plus an ignored start while busy.
    rb = rd_log.size(); wb = wr_addr_log.size(); nd = n_done;
    run_cmd("wrap", 16'hFFF8, 16'h0500, 5'd4, 1'b0, 32'h0, 5, done_at, busy_n, err_at);
    chk("wrap.done_at", done_at, 11);
    chk("wrap.ndone", n_done - nd, 1);
    chk("wrap.idle_after", busy, 0);
    chk("wrap.nrd", rd_log.size() - rb, 4);
    chk("wrap.nwr", wr_addr_log.size() - wb, 4);
    for (int k = 0; k < 4; k++) begin
      chk("wrap.raddr", rd_log[rb + k], wrap_a[k]);
      chk("wrap.waddr", wr_addr_log[wb + k], 32'h0500 + 4 * k);
      chk("wrap.wdata", wr_data_log[wb + k], mem[wrap_a[k][AW-1:2]]);
    end

    // Reset in the middle of the read phase with beats still in flight.
    rv_min = 4; rv_max = 4;
    @(negedge clk);
    cmd_src = 16'h0100; cmd_dst = 16'h0700; cmd_len = 5'd8; cmd_mode = 1'b0; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid.busy_before", busy, 1);
    chk("rstmid.outstanding", rq_due.size(), 2);
    nd = n_done; nv = n_rv_idle;
    rst_n = 1'b0;
    #1;
    chk("rstmid.busy", busy, 0);
    chk("rstmid.req", mem_req, 0);
    chk("rstmid.addr", mem_addr, 0);
    chk("rstmid.we", mem_we, 0);
    chk("rstmid.wdata", mem_wdata, 0);
    chk("rstmid.wstrb", mem_wstrb, 0);
    chk("rstmid.done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rstmid.stale_rv", n_rv_idle - nv, 2);
    chk("rstmid.idle", busy, 0);
    chk("rstmid.nodone", n_done - nd, 0);
    rv_min = 1; rv_max = 1;
    rb = rd_log.size(); wb = wr_addr_log.size();
    run_cmd("post", 16'h0800, 16'h0900, 5'd2, 1'b0, 32'h0, 0, done_at, busy_n, err_at);
    chk("post.done_at", done_at, 7);
    chk("post.err", err_at, 0);
    chk("post.nrd", rd_log.size() - rb, 2);
    chk("post.nwr", wr_addr_log.size() - wb, 2);
    for (int k = 0; k < 2; k++) begin
      chk("post.raddr", rd_log[rb + k], 32'h0800 + 4 * k);
      chk("post.waddr", wr_addr_log[wb + k], 32'h0900 + 4 * k);
      chk("post.wdata", wr_data_log[wb + k], 32'hC0DE0200 + k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
